// File: rtl/sparse_vec_decoder.sv
// Sparse vector decoder: fetches {index,value} words from SRAM and streams them as beats, then a done beat.
// Optional index-order checker is compiled in when SPARSE_DEC_IDX_CHECK_EN is defined.

package sparse_mac_pkg;
  localparam int INDEX_W = 16;
  localparam int VALUE_W = 16;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [VALUE_W-1:0] value;
    logic               done;
  } decoder_data_t;
endpackage

module sparse_vec_decoder
  import sparse_mac_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       mac_clk,
  input  logic                       mac_rst,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [ADDR_W-1:0]          nnz_i,
  output logic                       busy_o,
  output logic                       sram_rd_en_o,
  output logic [ADDR_W-1:0]          sram_addr_o,
  input  logic [INDEX_W+VALUE_W-1:0] sram_rdata_i,
  output logic                       decoder_valid_o,
  input  logic                       decoder_ready_i,
  output decoder_data_t              decoder_data_o,
  output logic                       idx_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_TAIL,
    ST_WAIT_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   nnz_q, nnz_d;
  logic [ADDR_W-1:0]   issued_q, issued_d;
  logic                inflight_q, inflight_d;
  decoder_data_t       head_q, head_d;
  logic                head_vld_q, head_vld_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  decoder_data_t       fifo_mem_q [FIFO_DEPTH];

  logic                rd_en;
  logic                tail_push;
  logic                credit_ok;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W:0]      occupancy;
  logic                pop;
  logic                head_free;
  logic                fifo_rd;
  logic                fifo_wr;
  logic                head_from_in;
  logic                in_valid;
  decoder_data_t       in_data;

  // Credit counts only registered state, so a pop in this cycle never frees a slot early.
  assign occupancy  = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok  = occupancy < DEPTH_OCC;
  assign fifo_full  = (fifo_cnt_q == DEPTH_CNT);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pop        = head_vld_q & decoder_ready_i;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    nnz_d     = nnz_q;
    issued_d  = issued_q;
    rd_en     = 1'b0;
    tail_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d   = base_addr_i;
          nnz_d    = nnz_i;
          issued_d = '0;
          state_d  = (nnz_i == '0) ? ST_TAIL : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (credit_ok) begin
          rd_en    = 1'b1;
          issued_d = issued_q + ADDR_W'(1);
          if (issued_d == nnz_q) state_d = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (!inflight_q && !fifo_full) begin
          tail_push = 1'b1;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (pop && head_q.done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign inflight_d = rd_en;
  assign in_valid   = inflight_q | tail_push;

  always_comb begin
    in_data = decoder_data_t'({sram_rdata_i, 1'b0});
    if (tail_push) in_data = '{index: '0, value: '0, done: 1'b1};
  end

  // The head register sits in front of the FIFO; an empty FIFO lets a fresh word bypass straight into it.
  always_comb begin
    head_free    = ~head_vld_q | pop;
    fifo_rd      = head_free & ~fifo_empty;
    head_from_in = head_free & fifo_empty & in_valid;
    fifo_wr      = in_valid & ~head_from_in;
    head_d       = head_q;
    head_vld_d   = head_vld_q;
    if (head_free) begin
      head_vld_d = fifo_rd | head_from_in;
      if (fifo_rd)           head_d = fifo_mem_q[rd_ptr_q];
      else if (head_from_in) head_d = in_data;
    end
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (fifo_wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (fifo_rd) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
  end

  always_ff @(posedge mac_clk or negedge mac_rst) begin
    if (!mac_rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      nnz_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      nnz_q      <= nnz_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge mac_clk) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= in_data;
  end

`ifdef SPARSE_DEC_IDX_CHECK_EN
  logic [INDEX_W-1:0] prev_idx_q, prev_idx_d;
  logic               have_prev_q, have_prev_d;
  logic               idx_err_q, idx_err_d;

  always_comb begin
    prev_idx_d  = prev_idx_q;
    have_prev_d = have_prev_q;
    idx_err_d   = idx_err_q;
    if (state_q == ST_IDLE && start_i) begin
      have_prev_d = 1'b0;
      idx_err_d   = 1'b0;
    end else if (pop && !head_q.done) begin
      if (have_prev_q && (head_q.index <= prev_idx_q)) idx_err_d = 1'b1;
      prev_idx_d  = head_q.index;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge mac_clk or negedge mac_rst) begin
    if (!mac_rst) begin
      prev_idx_q  <= '0;
      have_prev_q <= 1'b0;
      idx_err_q   <= 1'b0;
    end else begin
      prev_idx_q  <= prev_idx_d;
      have_prev_q <= have_prev_d;
      idx_err_q   <= idx_err_d;
    end
  end

  assign idx_err_o = idx_err_q;
`else
  assign idx_err_o = 1'b0;
`endif

  // busy covers the accepting cycle itself, hence the start_i term.
  assign busy_o          = (state_q != ST_IDLE) | start_i;
  assign sram_rd_en_o    = rd_en;
  assign sram_addr_o     = rd_en ? (base_q + issued_q) : '0;
  assign decoder_valid_o = head_vld_q;
  assign decoder_data_o  = head_q;

endmodule

// File: tb/tb_sparse_vec_decoder.sv
// Self-checking bench for sparse_vec_decoder: queue-based beat/address model plus directed literal checks.
// Define SPARSE_DEC_IDX_CHECK_EN to also exercise the index-order checker.

module tb_sparse_vec_decoder;
  import sparse_mac_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2;
`ifdef SPARSE_DEC_IDX_CHECK_EN
  localparam logic EXP_IDX_ERR = 1'b1;
`else
  localparam logic EXP_IDX_ERR = 1'b0;
`endif

  logic              mac_clk = 1'b0;
  logic              mac_rst = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [ADDR_W-1:0] nnz_i = '0;
  logic              busy_o;
  logic              sram_rd_en_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_rdata_i = '0;
  logic              decoder_valid_o;
  logic              decoder_ready_i = 1'b1;
  decoder_data_t     decoder_data_o;
  logic              idx_err_o;

  sparse_vec_decoder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .mac_clk         (mac_clk),
    .mac_rst         (mac_rst),
    .start_i         (start_i),
    .base_addr_i     (base_addr_i),
    .nnz_i           (nnz_i),
    .busy_o          (busy_o),
    .sram_rd_en_o    (sram_rd_en_o),
    .sram_addr_o     (sram_addr_o),
    .sram_rdata_i    (sram_rdata_i),
    .decoder_valid_o (decoder_valid_o),
    .decoder_ready_i (decoder_ready_i),
    .decoder_data_o  (decoder_data_o),
    .idx_err_o       (idx_err_o)
  );

  always #5 mac_clk = ~mac_clk;

  logic [31:0] sram [0:1023];
  always @(posedge mac_clk) if (sram_rd_en_o) sram_rdata_i <= sram[sram_addr_o];

  int cyc = 0;
  always @(posedge mac_clk) cyc <= cyc + 1;

  int n_vec = 0, n_fail = 0;
  logic [32:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [32:0]       seen_q[$];
  logic [ADDR_W-1:0] seen_addr_q[$];
  int  reads = 0, acc_data = 0, acc_run = 0, done_cnt = 0;
  int  start_cyc = 0, first_cyc = 0, done_cyc = 0, occ = 0;
  bit  mon_en = 0, run_active = 0, prev_stall = 0;
  bit  model_err = 0, have_prev = 0;
  logic [15:0] prev_idx = '0;
  logic [32:0] prev_data = '0, d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Per-cycle compare against the queue model.
  always @(negedge mac_clk) begin
    if (mon_en) begin
      d   = decoder_data_o;
      occ = reads - acc_data - ((decoder_valid_o && !d[0]) ? 1 : 0);
      chk("occupancy_le_depth", 64'(occ <= DEPTH), 64'd1);
      if (prev_stall) begin
        chk("stall_valid", decoder_valid_o, 1'b1);
        chk("stall_data", d, prev_data);
      end
      chk("idx_err", idx_err_o, model_err);
      if (run_active) chk("busy_in_run", busy_o, 1'b1);
      else            chk("busy_idle", busy_o, 1'b0);
      if (sram_rd_en_o) begin
        seen_addr_q.push_back(sram_addr_o);
        if (exp_addr_q.size() == 0) flag("extra_read");
        else chk("rd_addr", sram_addr_o, exp_addr_q.pop_front());
        reads++;
      end
      if (decoder_valid_o && decoder_ready_i) begin
        $display("beat cyc=%0d idx=%0d val=%0d done=%0b", cyc, d[32:17], d[16:1], d[0]);
        seen_q.push_back(d);
        if (exp_q.size() == 0) flag("extra_beat");
        else chk("beat", d, exp_q.pop_front());
        if (acc_run == 0) first_cyc = cyc;
        acc_run++;
        if (d[0]) begin
          done_cnt++;
          done_cyc   = cyc;
          run_active = 0;
        end else begin
          acc_data++;
`ifdef SPARSE_DEC_IDX_CHECK_EN
          if (have_prev && d[32:17] <= prev_idx) model_err = 1;
          prev_idx  = d[32:17];
          have_prev = 1;
`endif
        end
      end
      prev_stall = decoder_valid_o && !decoder_ready_i;
      prev_data  = d;
    end
  end

  task automatic tick();
    @(posedge mac_clk);
    #1;
  endtask

  task automatic launch(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] nnz);
    for (int i = 0; i < int'(nnz); i++) begin
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_q.push_back({sram[a], 1'b0});
    end
    exp_q.push_back(33'h1);
    seen_q.delete();
    seen_addr_q.delete();
    acc_run     = 0;
    start_cyc   = cyc;
    base_addr_i = base;
    nnz_i       = nnz;
    start_i     = 1'b1;
    run_active  = 1;
    tick();
    start_i   = 1'b0;
    model_err = 0;
    have_prev = 0;
  endtask

  // mode 0: ready held high; mode 1: low for 10 cycles, then toggling.
  task automatic wait_done(input int mode, input int budget);
    int t = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && t < budget) begin
      if (mode == 0) decoder_ready_i = 1'b1;
      else           decoder_ready_i = (t < 10) ? 1'b0 : ((t % 2) == 0);
      tick();
      t++;
    end
    if (done_cnt == d0) flag("done_timeout");
    decoder_ready_i = 1'b1;
    @(negedge mac_clk);
    chk("busy_drop", busy_o, 1'b0);
    chk("valid_after_done", decoder_valid_o, 1'b0);
    chk("model_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {busy_o, sram_rd_en_o, sram_addr_o, decoder_valid_o, decoder_data_o, idx_err_o}, '0);
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 1024; i++) sram[i] = {16'(i * 2 + 1), 16'(i) ^ 16'hA5A5};
    sram[10'h010] = {16'd2, 16'd5};
    sram[10'h011] = {16'd7, 16'd9};
    sram[10'h012] = {16'd12, 16'd1};
    sram[10'h040] = {16'd4, 16'd1};
    sram[10'h041] = {16'd4, 16'd2};
    sram[10'h042] = {16'd9, 16'd3};

    // Reset state
    @(negedge mac_clk);
    @(negedge mac_clk);
    chk_all_zero("reset_outputs");
    tick();
    mac_rst = 1'b1;
    mon_en  = 1;
    tick();

    // nnz=3 basic run
    launch(10'h010, 10'd3);
    wait_done(0, 40);
    chk("n3_first_latency", 64'(first_cyc - start_cyc), 64'd3);
    chk("n3_back_to_back", 64'(done_cyc - first_cyc), 64'd3);
    chk("n3_nbeats", 64'(seen_q.size()), 64'd4);
    if (seen_q.size() == 4) begin
      chk("n3_beat0", seen_q[0], {16'd2, 16'd5, 1'b0});
      chk("n3_beat1", seen_q[1], {16'd7, 16'd9, 1'b0});
      chk("n3_beat2", seen_q[2], {16'd12, 16'd1, 1'b0});
      chk("n3_beat3", seen_q[3], 33'h1);
    end
    chk("n3_nreads", 64'(seen_addr_q.size()), 64'd3);
    if (seen_addr_q.size() == 3) begin
      chk("n3_addr0", seen_addr_q[0], 10'h010);
      chk("n3_addr2", seen_addr_q[2], 10'h012);
    end
    tick();

    // nnz=0: single done beat, no reads
    r0 = reads;
    launch(10'h055, 10'd0);
    wait_done(0, 20);
    chk("n0_no_reads", 64'(reads - r0), 64'd0);
    chk("n0_nbeats", 64'(seen_q.size()), 64'd1);
    if (seen_q.size() == 1) chk("n0_done_beat", seen_q[0], 33'h1);
    tick();

    // nnz=5 with back-pressure
    decoder_ready_i = 1'b0;
    tick();
    launch(10'h020, 10'd5);
    wait_done(1, 100);
    chk("n5_nbeats", 64'(seen_q.size()), 64'd6);
    tick();

    // address wrap
    launch(10'h3FE, 10'd4);
    wait_done(0, 40);
    chk("wrap_nreads", 64'(seen_addr_q.size()), 64'd4);
    if (seen_addr_q.size() == 4) begin
      chk("wrap_addr0", seen_addr_q[0], 10'h3FE);
      chk("wrap_addr1", seen_addr_q[1], 10'h3FF);
      chk("wrap_addr2", seen_addr_q[2], 10'h000);
      chk("wrap_addr3", seen_addr_q[3], 10'h001);
    end
    tick();

    // start while busy is ignored
    r0 = reads;
    launch(10'h030, 10'd3);
    tick();
    base_addr_i = 10'h000;
    nnz_i       = 10'd1;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(0, 40);
    chk("busy_start_nreads", 64'(reads - r0), 64'd3);
    chk("busy_start_nbeats", 64'(seen_q.size()), 64'd4);
    tick();

    // index order 4,4,9
    launch(10'h040, 10'd3);
    wait_done(0, 40);
    chk("idx_nbeats", 64'(seen_q.size()), 64'd4);
    chk("idx_err_final", idx_err_o, EXP_IDX_ERR);
    tick();

    // reset mid-fetch after two beats
    begin
      int t = 0;
      launch(10'h100, 10'd8);
      while (acc_run < 2 && t < 20) begin
        tick();
        t++;
      end
      if (acc_run < 2) flag("pre_reset_timeout");
      mon_en  = 0;
      mac_rst = 1'b0;
      @(negedge mac_clk);
      chk_all_zero("midrun_reset_outputs");
      exp_q.delete();
      exp_addr_q.delete();
      reads = 0; acc_data = 0; prev_stall = 0;
      model_err = 0; have_prev = 0; run_active = 0;
      tick();
      tick();
      mac_rst = 1'b1;
      mon_en  = 1;
      tick();
    end
    launch(10'h200, 10'd1);
    wait_done(0, 20);
    chk("post_reset_nbeats", 64'(seen_q.size()), 64'd2);
    if (seen_q.size() == 2) begin
      chk("post_reset_beat0", seen_q[0], {16'h0401, 16'hA7A5, 1'b0});
      chk("post_reset_beat1", seen_q[1], 33'h1);
    end
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
